// File: rtl/rxfifo_axis_rdctrl.sv
// Read-side controller for the AXIS bridge RX path: drains the length and data
// FIFOs and emits each frame as an AXI-Stream packet with tkeep/tlast.
`timescale 1ns/1ps

module rxfifo_axis_rdctrl #(
  parameter int DWIDTH = 64,
  parameter int KEEPW  = 8,
  parameter int LWIDTH = 14
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              len_rdempty,
  output logic              len_rden,
  input  logic [LWIDTH-1:0] len_dataout,
  input  logic              dat_rdempty,
  output logic              dat_rden,
  input  logic [DWIDTH-1:0] dat_dataout,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic [KEEPW-1:0]  m_axis_tkeep,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [31:0]       pkt_cnt,
  output logic              err_zero_len,
  output logic              busy
);

  localparam int KBITS  = $clog2(KEEPW);
  localparam int BWIDTH = LWIDTH - KBITS + 1;

  typedef enum logic [1:0] {IDLE, LEN_WAIT, DATA} state_t;

  state_t              state_q, state_d;
  logic                active_q;
  logic [BWIDTH-1:0]   rd_left_q, rd_left_d;
  logic [BWIDTH-1:0]   beat_left_q, beat_left_d;
  logic [KBITS-1:0]    rem_q, rem_d;
  logic                inflight_q;
  logic [DWIDTH-1:0]   buf0_q, buf0_d;
  logic [DWIDTH-1:0]   buf1_q, buf1_d;
  logic [1:0]          occ_q, occ_d;
  logic [31:0]         pkt_cnt_q, pkt_cnt_d;
  logic                err_q, err_d;

  logic                tvalid;
  logic                pop;
  logic                last_beat;
  logic [2:0]          slots_used;
  logic                room;
  logic [KBITS-1:0]    len_rem;
  logic [BWIDTH-1:0]   len_beats;
  logic [KEEPW-1:0]    last_mask;

  assign tvalid     = (occ_q != 2'd0);
  assign pop        = tvalid && m_axis_tready;
  assign last_beat  = (beat_left_q == BWIDTH'(1));
  assign slots_used = {1'b0, occ_q} + {2'b00, inflight_q};
  // A pop this cycle frees the slot that a read issued now will land in next cycle.
  assign room       = (slots_used < 3'd2) || pop;
  assign len_rem    = len_dataout[KBITS-1:0];
  assign len_beats  = BWIDTH'(len_dataout >> KBITS) + BWIDTH'(len_rem != '0);

  assign dat_rden = (state_q == DATA) && (rd_left_q != '0) && !dat_rdempty && room;

  always_comb begin
    last_mask = {KEEPW{1'b1}};
    if (rem_q != '0) begin
      last_mask = ~({KEEPW{1'b1}} << rem_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    len_rden    = 1'b0;
    rd_left_d   = rd_left_q;
    beat_left_d = beat_left_q;
    rem_d       = rem_q;
    pkt_cnt_d   = pkt_cnt_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (active_q && !len_rdempty) begin
          len_rden = 1'b1;
          state_d  = LEN_WAIT;
        end
      end
      LEN_WAIT: begin
        if (len_dataout == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          rd_left_d   = len_beats;
          beat_left_d = len_beats;
          rem_d       = len_rem;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (dat_rden) begin
          rd_left_d = rd_left_q - BWIDTH'(1);
        end
        if (pop) begin
          beat_left_d = beat_left_q - BWIDTH'(1);
          if (last_beat) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-entry skid buffer; buf0 is always the head presented on the stream.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    if (inflight_q && !pop) begin
      if (occ_q == 2'd0) begin
        buf0_d = dat_dataout;
      end else begin
        buf1_d = dat_dataout;
      end
      occ_d = occ_q + 2'd1;
    end else if (pop && !inflight_q) begin
      buf0_d = buf1_q;
      occ_d  = occ_q - 2'd1;
    end else if (pop && inflight_q) begin
      if (occ_q == 2'd1) begin
        buf0_d = dat_dataout;
      end else begin
        buf0_d = buf1_q;
        buf1_d = dat_dataout;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= IDLE;
      active_q    <= 1'b0;
      rd_left_q   <= '0;
      beat_left_q <= '0;
      rem_q       <= '0;
      inflight_q  <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      occ_q       <= 2'd0;
      pkt_cnt_q   <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= 1'b1;
      rd_left_q   <= rd_left_d;
      beat_left_q <= beat_left_d;
      rem_q       <= rem_d;
      inflight_q  <= dat_rden;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      occ_q       <= occ_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_q       <= err_d;
    end
  end

  assign m_axis_tdata  = buf0_q;
  assign m_axis_tvalid = tvalid;
  assign m_axis_tlast  = tvalid && last_beat;
  assign m_axis_tkeep  = tvalid ? (last_beat ? last_mask : {KEEPW{1'b1}}) : '0;
  assign pkt_cnt       = pkt_cnt_q;
  assign err_zero_len  = err_q;
  assign busy          = (state_q != IDLE) || (occ_q != 2'd0);

endmodule
